mem_access_ctrl: RTL

Initiator-side memory access controller that issues single load/store transactions to the 512x8 byte-addressed data RAM on behalf of the CPU datapath. It converts a one-cycle CPU request into the RAM's level-sensitive enable/readWrite/MAS protocol. It then waits for the RAM's done flag, shapes load data (zero or sign extension) and returns a one-cycle acknowledge. It sits between the load/store unit and the RAM.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_access_ctrl_load_extender.sv | 20 ++
 rtl/mem_access_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and FSM state type for the initiator-side memory access controller.
package mem_ctrl_pkg;

  localparam logic [1:0] MAS_BYTE    = 2'b00;
  localparam logic [1:0] MAS_HALF    = 2'b01;
  localparam logic [1:0] MAS_WORD    = 2'b10;
  localparam logic [1:0] MAS_ILLEGAL = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Halfwords must sit on even addresses, words on 4-byte boundaries.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return ((size == MAS_HALF) && lsb[0]) || ((size == MAS_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request bus and RAM-side level-sensitive bus of the memory access controller.
interface cpu_bus_if #(parameter int ADDR_W = 9);
  logic              req;
  logic              rw;
  logic [1:0]        size;
  logic              signed_ld;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              ack;
  logic              err;
  logic [31:0]       rdata;

  modport master (output req, rw, size, signed_ld, addr, wdata,
                  input  busy, ack, err, rdata);
  modport slave  (input  req, rw, size, signed_ld, addr, wdata,
                  output busy, ack, err, rdata);
endinterface

interface ram_bus_if #(parameter int ADDR_W = 9);
  logic              ram_enable;
  logic              ram_readWrite;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_dataIn;
  logic [1:0]        ram_MAS;
  logic              ram_done;
  logic [31:0]       ram_dataOut;

  modport master (output ram_enable, ram_readWrite, ram_address, ram_dataIn, ram_MAS,
                  input  ram_done, ram_dataOut);
  modport slave  (input  ram_enable, ram_readWrite, ram_address, ram_dataIn, ram_MAS,
                  output ram_done, ram_dataOut);
endinterface

// File: rtl/mem_access_ctrl_load_extender.sv
// Combinational load-data shaping: zero or sign extension of byte/halfword reads.
module load_extender
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] d,
  input  logic [1:0]  size,
  input  logic        signed_ld,
  output logic [31:0] q
);

  always_comb begin
    q = d;
    case (size)
      MAS_BYTE: q = {{24{signed_ld & d[7]}}, d[7:0]};
      MAS_HALF: q = {{16{signed_ld & d[15]}}, d[15:0]};
      default:  q = d;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-transaction load/store controller driving the 512x8 data RAM.
// Optional build macro MEM_ALIGN_CHECK_EN rejects misaligned halfword/word requests.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for req; RAM disabled
// ST_ACCESS | ram_enable held, counting settle/timeout, waiting ram_done
// ST_RESP   | one-cycle ack (err valid), RAM disabled, back to idle
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 16
)(
  input  logic       clk,
  input  logic       reset_n,
  cpu_bus_if.slave   cpu,
  ram_bus_if.master  ram
);

  localparam logic [7:0] SETTLE_M1  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT_CYCLES - 1);

  state_t            state, state_d;
  logic [7:0]        cnt, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              en_q, en_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [1:0]        mas_q, mas_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       shaped;
  logic              align_fault;

`ifdef MEM_ALIGN_CHECK_EN
  assign align_fault = misaligned(cpu.size, cpu.addr[1:0]);
`else
  assign align_fault = 1'b0;
`endif

  load_extender u_load_extender (
    .d         (ram.ram_dataOut),
    .size      (mas_q),
    .signed_ld (sgn_q),
    .q         (shaped)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      en_q    <= 1'b0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      din_q   <= 32'd0;
      mas_q   <= MAS_BYTE;
      sgn_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      mas_q   <= mas_d;
      sgn_q   <= sgn_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    en_d    = en_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    din_d   = din_q;
    mas_d   = mas_q;
    sgn_d   = sgn_q;

    case (state)
      ST_IDLE: begin
        if (cpu.req) begin
          if ((cpu.size == MAS_ILLEGAL) || align_fault) begin
            state_d = ST_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            en_d    = 1'b1;
            rw_d    = cpu.rw;
            addr_d  = cpu.addr;
            din_d   = cpu.wdata;
            mas_d   = cpu.size;
            sgn_d   = cpu.signed_ld;
            cnt_d   = 8'd0;
          end
        end
      end

      ST_ACCESS: begin
        cnt_d = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        // A done that arrives before the settle window closes is ignored.
        if ((cnt >= SETTLE_M1) && ram.ram_done) begin
          state_d = ST_RESP;
          en_d    = 1'b0;
          ack_d   = 1'b1;
          if (rw_q == RW_READ) rdata_d = shaped;
        end else if (cnt == TIMEOUT_M1) begin
          state_d = ST_RESP;
          en_d    = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  assign cpu.busy  = (state != ST_IDLE);
  assign cpu.ack   = ack_q;
  assign cpu.err   = err_q;
  assign cpu.rdata = rdata_q;

  assign ram.ram_enable    = en_q;
  assign ram.ram_readWrite = rw_q;
  assign ram.ram_address   = addr_q;
  assign ram.ram_dataIn    = din_q;
  assign ram.ram_MAS       = mas_q;

endmodule
